// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its
// round-robin picker.
//   state_t          : arbiter FSM state (IDLE between grants, GRANT while a
//                      requester owns the FIFO write port)
//   id_width()       : requester-ID width for a given requester count
//   burst_cnt_width(): width of a counter that must hold 0..max_burst
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Never returns 0, so an ID field always exists even for one requester.
  function automatic int id_width(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle of the write arbiter.
//   req_dv    : per-requester data valid (held until accepted)
//   req_data  : packed payloads, requester k at [k*WIDTH +: WIDTH]
//   req_ready : per-requester accept, one-hot or zero
//   full      : FIFO full flag including same-cycle write look-ahead
//   wr_dv     : FIFO write strobe
//   wr_data   : {requester ID, payload}, ID in the MSBs
//   busy      : a grant is in progress
//   grant_id  : current or most recent granted requester
// Modports: master = producers/FIFO side, slave = arbiter side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) ();

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req_dv;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     full;
  logic                     wr_dv;
  logic [WIDTH+ID_W-1:0]    wr_data;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;

  modport master (
    output req_dv, req_data, full,
    input  req_ready, wr_dv, wr_data, busy, grant_id
  );

  modport slave (
    input  req_dv, req_data, full,
    output req_ready, wr_dv, wr_data, busy, grant_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational round-robin picker: finds the first set bit of req searching
// last+1, last+2, ... modulo NUM_REQ (last itself is checked last).
//   req   : request vector
//   last  : index served most recently
//   found : at least one request bit set
//   pick  : chosen index (0 when nothing found)
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               found,
  output logic [ID_W-1:0]    pick
);

  // One spare bit: last + offset stays below 2*NUM_REQ, so a single
  // conditional subtract implements the modulo for any NUM_REQ.
  logic [ID_W:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NUM_REQ producers with round-robin
// grants of at most MAX_BURST words, honouring the FIFO full flag and tagging
// every written word with its requester ID.
//   i_Clk    : clock, rising edge
//   i_Rst_L  : asynchronous active-low reset
//   i_Enable : gates new grants only; a running burst always completes
//   bus      : fifo_wr_arbiter_if.slave (requests, ready, full, FIFO write)
// Accepted words appear on wr_dv/wr_data exactly one cycle after acceptance.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  fifo_wr_arbiter_if.slave    bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = burst_cnt_width(MAX_BURST);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  RST_LAST  = ID_W'(NUM_REQ - 1);

  state_t                state, state_nxt;
  logic [ID_W-1:0]       r_grant, grant_nxt;
  logic [ID_W-1:0]       r_last, last_nxt;
  logic [CNT_W-1:0]      burst_cnt, cnt_nxt;
  logic                  found;
  logic [ID_W-1:0]       pick;
  logic                  grant_dv;
  logic [WIDTH-1:0]      payload;
  logic [NUM_REQ-1:0]    ready;
  logic                  xfer;
  logic                  wr_dv;
  logic [WIDTH+ID_W-1:0] wr_data;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (bus.req_dv),
    .last  (r_last),
    .found (found),
    .pick  (pick)
  );

  // Valid and payload of the granted requester.
  always_comb begin
    grant_dv = 1'b0;
    payload  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == r_grant) begin
        grant_dv = bus.req_dv[k];
        payload  = bus.req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state == GRANT && !bus.full) begin
      ready[r_grant] = 1'b1;
    end
  end

  assign xfer = (state == GRANT) && grant_dv && !bus.full;

  always_comb begin
    state_nxt = state;
    grant_nxt = r_grant;
    last_nxt  = r_last;
    cnt_nxt   = burst_cnt;
    unique case (state)
      IDLE: begin
        if (i_Enable && found && !bus.full) begin
          state_nxt = GRANT;
          grant_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!grant_dv) begin
          state_nxt = IDLE;
          last_nxt  = r_grant;
        end else if (!bus.full) begin
          if (burst_cnt == LAST_BEAT) begin
            state_nxt = IDLE;
            last_nxt  = r_grant;
          end else begin
            cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      r_grant   <= '0;
      r_last    <= RST_LAST;
      burst_cnt <= '0;
      wr_dv     <= 1'b0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      r_grant   <= grant_nxt;
      r_last    <= last_nxt;
      burst_cnt <= cnt_nxt;
      wr_dv     <= xfer;
      if (xfer) begin
        wr_data <= {r_grant, payload};
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.wr_dv     = wr_dv;
  assign bus.wr_data   = wr_data;
  assign bus.busy      = (state == GRANT);
  assign bus.grant_id  = r_grant;

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
    $onehot0(ready));

  a_no_xfer_when_full : assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
    !((|(bus.req_dv & ready)) && bus.full));

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_hold
    a_req_held : assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
      (bus.req_dv[k] && !ready[k]) |=>
        (bus.req_dv[k] && $stable(bus.req_data[k*WIDTH +: WIDTH])));
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a queue/integer level model of the
// round-robin write arbiter is compared with the DUT on every falling edge;
// directed scenarios add literal expectations, then a randomized run follows.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;
  localparam int DW        = WIDTH + ID_W;

  logic i_Clk = 1'b0;
  logic i_Rst_L;
  logic i_Enable;

  logic [NUM_REQ-1:0]       dv;
  logic [NUM_REQ-1:0]       acc;
  logic [WIDTH-1:0]         pay [NUM_REQ];
  logic                     full;
  logic [NUM_REQ*WIDTH-1:0] data_bus;
  int                       budget [NUM_REQ];
  int                       p_new;

  int n_vec = 0;
  int n_bad = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Enable (i_Enable),
    .bus      (bus)
  );

  always_comb begin
    data_bus = '0;
    for (int k = 0; k < NUM_REQ; k++) data_bus[k*WIDTH +: WIDTH] = pay[k];
  end

  assign bus.req_dv   = dv;
  assign bus.req_data = data_bus;
  assign bus.full     = full;

  initial forever #5 i_Clk = ~i_Clk;

  // Producers must hold valid and payload until accepted.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req_rule
    a_hold : assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
      (dv[k] && !bus.req_ready[k]) |=> (dv[k] && $stable(pay[k])))
      else $error("requester %0d changed before acceptance", k);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_owner = -1;   // granted requester, -1 when none
  int               m_taken = 0;    // words taken in the current grant
  int               m_last  = NUM_REQ - 1;
  int               m_gid   = 0;
  logic             m_wr_dv = 1'b0;
  logic [DW-1:0]    m_wr_data = '0;

  int               grant_log [$];
  logic [DW-1:0]    wr_log [$];
  logic             prev_busy = 1'b0;

  always @(negedge i_Clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    int c;
    if (!i_Rst_L) begin
      m_owner = -1; m_taken = 0; m_last = NUM_REQ - 1; m_gid = 0;
      m_wr_dv = 1'b0; m_wr_data = '0;
    end
    exp_ready = '0;
    if (m_owner >= 0 && !full) exp_ready[m_owner] = 1'b1;
    check("ready",    32'(bus.req_ready), 32'(exp_ready));
    check("wr_dv",    32'(bus.wr_dv),     32'(m_wr_dv));
    check("wr_data",  32'(bus.wr_data),   32'(m_wr_data));
    check("busy",     32'(bus.busy),      32'(m_owner >= 0));
    check("grant_id", 32'(bus.grant_id),  32'(m_gid));

    if (bus.busy && !prev_busy) grant_log.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;
    if (bus.wr_dv) wr_log.push_back(bus.wr_data);
    acc = dv & bus.req_ready;

    if (i_Rst_L) begin
      if (m_owner < 0) begin
        m_wr_dv = 1'b0;
        if (i_Enable && (|dv) && !full) begin
          for (int s = 1; s <= NUM_REQ; s++) begin
            c = (m_last + s) % NUM_REQ;
            if (dv[c]) begin
              m_owner = c;
              break;
            end
          end
          m_taken = 0;
          m_gid   = m_owner;
        end
      end else if (!dv[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_wr_dv = 1'b0;
      end else if (full) begin
        m_wr_dv = 1'b0;
      end else begin
        m_wr_dv   = 1'b1;
        m_wr_data = {ID_W'(m_owner), pay[m_owner]};
        m_taken++;
        if (m_taken == MAX_BURST) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!dv[k] || acc[k]) begin
        if (budget[k] > 0 && int'($urandom_range(0, 99)) < p_new) begin
          dv[k]  = 1'b1;
          pay[k] = WIDTH'($urandom);
          budget[k]--;
        end else begin
          dv[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
    drive();
  endtask

  task automatic wait_neg();
    @(negedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Rst_L = 1'b0;
    acc  = '0;
    dv   = '0;
    full = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) budget[k] = 0;
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    grant_log.delete();
    wr_log.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < NUM_REQ; k++) budget[k] = 0;
    full = 1'b0;
    i_Enable = 1'b1;
    repeat (12) begin
      wait_neg();
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit reflag;
    i_Rst_L  = 1'b1;
    i_Enable = 1'b0;
    full     = 1'b0;
    dv       = '0;
    acc      = '0;
    p_new    = 100;
    for (int k = 0; k < NUM_REQ; k++) begin
      pay[k] = '0;
      budget[k] = 0;
    end
    #2;

    // Single requester 2 with payload 0xA5.
    do_reset();
    i_Enable = 1'b1;
    dv[2]  = 1'b1;
    pay[2] = 8'hA5;
    wait_neg();
    check("s1_c0_busy", 32'(bus.busy), 32'd0);
    tick();
    wait_neg();
    check("s1_c1_busy",  32'(bus.busy),      32'd1);
    check("s1_c1_grant", 32'(bus.grant_id),  32'd2);
    check("s1_c1_ready", 32'(bus.req_ready), 32'h4);
    tick();
    wait_neg();
    check("s1_c2_wr_dv",   32'(bus.wr_dv),   32'd1);
    check("s1_c2_wr_data", 32'(bus.wr_data), 32'h2A5);
    check("s1_c2_busy",    32'(bus.busy),    32'd1);
    tick();
    wait_neg();
    check("s1_c3_busy", 32'(bus.busy), 32'd0);
    tick();

    // All requesters continuously valid.
    do_reset();
    p_new = 100;
    for (int k = 0; k < NUM_REQ; k++) budget[k] = 1000;
    drive();
    for (int c = 0; c <= 24; c++) begin
      wait_neg();
      if (c == 20) check("s2_words_by_c20", 32'(wr_log.size()), 32'd16);
      tick();
    end
    check("s2_grant_count", 32'(grant_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check("s2_grant_order", 32'(grant_log[i]), 32'(i % NUM_REQ));
    for (int i = 0; i < 16; i++)
      if (i < wr_log.size()) check("s2_word_id", 32'(wr_log[i][DW-1:WIDTH]), 32'(i / MAX_BURST));
    drain();

    // Requester 1 stops after two words; requester 2 must be next.
    do_reset();
    budget[1] = 2;
    budget[2] = 2;
    drive();
    reflag = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      wait_neg();
      if (!reflag && bus.busy && bus.grant_id == 2'd1 && !dv[1] && budget[1] == 0) begin
        budget[1] = 2;
        reflag = 1'b1;
      end
      tick();
    end
    check("s3_grants", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() >= 3) begin
      check("s3_grant0", 32'(grant_log[0]), 32'd1);
      check("s3_grant1", 32'(grant_log[1]), 32'd2);
      check("s3_grant2", 32'(grant_log[2]), 32'd1);
    end
    check("s3_words", 32'(wr_log.size()), 32'd6);
    drain();

    // FIFO full for five cycles after word 2 of a burst.
    do_reset();
    budget[0] = 4;
    drive();
    for (int c = 0; c <= 12; c++) begin
      full = (c >= 3 && c <= 7);
      wait_neg();
      if (c >= 3 && c <= 7) check("s4_ready_full", 32'(bus.req_ready), 32'd0);
      if (c >= 4 && c <= 8) check("s4_no_write",   32'(bus.wr_dv),     32'd0);
      if (c == 8)  check("s4_resume_ready", 32'(bus.req_ready), 32'h1);
      if (c == 10) begin
        check("s4_idle_after_4", 32'(bus.busy), 32'd0);
        check("s4_words",        32'(wr_log.size()), 32'd4);
      end
      tick();
    end
    drain();

    // Enable gating.
    do_reset();
    i_Enable = 1'b0;
    budget[3] = 1000;
    drive();
    for (int c = 0; c <= 16; c++) begin
      i_Enable = (c >= 6 && c <= 7);
      wait_neg();
      if (c <= 6) check("s5_no_grant", 32'(bus.busy), 32'd0);
      if (c == 16) begin
        check("s5_idle",   32'(bus.busy),           32'd0);
        check("s5_words",  32'(wr_log.size()),      32'd4);
        check("s5_grants", 32'(grant_log.size()),   32'd1);
      end
      tick();
    end
    drain();

    // Reset while a word is being accepted.
    do_reset();
    i_Enable = 1'b1;
    budget[1] = 1000;
    drive();
    wait_neg(); tick();
    wait_neg(); tick();
    wait_neg();
    check("s6_pre_wr_dv", 32'(bus.wr_dv), 32'd1);
    #1;
    i_Rst_L = 1'b0;
    acc = '0;
    #1;
    check("s6_async_wr_dv", 32'(bus.wr_dv), 32'd0);
    check("s6_async_busy",  32'(bus.busy),  32'd0);
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    grant_log.delete();
    wr_log.delete();
    budget[0] = 1;
    drive();
    wait_neg();
    check("s6_r0_wr_dv", 32'(bus.wr_dv), 32'd0);
    tick();
    wait_neg();
    check("s6_r1_wr_dv", 32'(bus.wr_dv),    32'd0);
    check("s6_r1_grant", 32'(bus.grant_id), 32'd0);
    tick();
    wait_neg();
    check("s6_r2_wr_dv",   32'(bus.wr_dv),   32'd1);
    check("s6_r2_wr_data_id", 32'(bus.wr_data[DW-1:WIDTH]), 32'd0);
    tick();
    if (grant_log.size() > 0) check("s6_first_grant", 32'(grant_log[0]), 32'd0);
    else check("s6_first_grant_seen", 32'd0, 32'd1);
    drain();

    // Randomized traffic.
    do_reset();
    p_new = 60;
    for (int k = 0; k < NUM_REQ; k++) budget[k] = 100000;
    i_Enable = 1'b1;
    drive();
    for (int c = 0; c < 800; c++) begin
      wait_neg();
      @(posedge i_Clk);
      #1;
      i_Enable = ($urandom_range(0, 9) != 0);
      full     = ($urandom_range(0, 3) == 0);
      drive();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
